// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - AHB round-robin bus arbiter with locked-transfer and fixed-burst tracking
module ahb_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic [MW-1:0]          HMASTER_DATA,
    output logic                   HMASTLOCK
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [1:0] RESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        PARK,
        ACTIVE,
        BURST
    } state_t;

    state_t        state;
    logic [4:0]    beats_left;
    logic [4:0]    burst_load;
    logic          is_error;
    logic          arb_point;
    logic          found;
    logic [MW-1:0] winner;
    logic [MW-1:0] idx_m;
    int            idx;

    // Beats remaining after the NONSEQ; zero means SINGLE/INCR (no count)
    always_comb begin
        burst_load = 5'd0;
        case (HBURST)
            3'b010, 3'b011: burst_load = 5'd3;
            3'b100, 3'b101: burst_load = 5'd7;
            3'b110, 3'b111: burst_load = 5'd15;
            default:        burst_load = 5'd0;
        endcase
    end

    always_comb begin
        is_error  = (HRESP == RESP_ERROR);
        arb_point = 1'b0;
        if (HREADY) begin
            if (is_error) begin
                arb_point = 1'b1;
            end else if (state == BURST) begin
                arb_point = (HTRANS == TRANS_IDLE) ||
                            (HTRANS == TRANS_SEQ && beats_left == 5'd1);
            end else begin
                arb_point = !HLOCK[HMASTER];
            end
        end
    end

    // Round-robin search starting after the owner; the owner is visited last
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_m  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx   = (int'(HMASTER) + i) % NUM_MASTERS;
            idx_m = MW'(idx);
            if (!found && HBUSREQ[idx_m]) begin
                found  = 1'b1;
                winner = idx_m;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= PARK;
            beats_left   <= 5'd0;
            HGRANT       <= NUM_MASTERS'(1);
            HMASTER      <= '0;
            HMASTER_DATA <= '0;
            HMASTLOCK    <= 1'b0;
        end else if (HREADY) begin
            HMASTER_DATA <= HMASTER;
            if (arb_point) begin
                HMASTER   <= winner;
                HGRANT    <= NUM_MASTERS'(1) << winner;
                HMASTLOCK <= found && HLOCK[winner];
                if (!found) begin
                    state      <= PARK;
                    beats_left <= 5'd0;
                end else if (HTRANS == TRANS_NONSEQ && !is_error &&
                             winner == HMASTER && burst_load != 5'd0) begin
                    // Owner kept the bus, so its new burst is counted
                    state      <= BURST;
                    beats_left <= burst_load;
                end else begin
                    state      <= ACTIVE;
                    beats_left <= 5'd0;
                end
            end else if (HTRANS == TRANS_NONSEQ) begin
                state      <= (burst_load != 5'd0) ? BURST : ACTIVE;
                beats_left <= burst_load;
            end else if (state == BURST && HTRANS == TRANS_SEQ) begin
                beats_left <= beats_left - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - self-checking bench for ahb_arbiter against a behavioural model
module tb_ahb_arbiter;

    localparam int N = 4;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] ERROR  = 2'b01;
    localparam int M_PARK = 0, M_ACTIVE = 1, M_BURST = 2;

    logic         HCLK;
    logic         HRESET;
    logic [N-1:0] HBUSREQ;
    logic [N-1:0] HLOCK;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST;
    logic         HREADY;
    logic [1:0]   HRESP;
    logic [N-1:0] HGRANT;
    logic [1:0]   HMASTER;
    logic [1:0]   HMASTER_DATA;
    logic         HMASTLOCK;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 0;

    int m_owner = 0, m_data = 0, m_lock = 0, m_beats = 0, m_mode = M_PARK;
    int m_win, m_len;
    bit m_err, m_decide, m_start;

    ahb_arbiter #(.NUM_MASTERS(N)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
        .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTER_DATA(HMASTER_DATA),
        .HMASTLOCK(HMASTLOCK)
    );

    initial HCLK = 0;
    always #5 HCLK = ~HCLK;

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        return ((v >> i) & 1) != 0;
    endfunction

    function automatic int burst_total(input logic [2:0] b);
        if (b[2:1] == 2'b01) return 4;
        if (b[2:1] == 2'b10) return 8;
        if (b[2:1] == 2'b11) return 16;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: who owns the bus and how many beats of a fixed burst remain
    always @(posedge HCLK) begin
        if (HRESET) begin
            m_owner = 0; m_data = 0; m_lock = 0; m_beats = 0; m_mode = M_PARK;
        end else if (HREADY) begin
            m_err = (HRESP == ERROR);
            m_len = burst_total(HBURST);
            if (m_err)                 m_decide = 1;
            else if (m_mode == M_BURST) m_decide = (HTRANS == IDLE) || (HTRANS == SEQ && m_beats == 1);
            else                       m_decide = !bit_of(HLOCK, m_owner);
            m_data = m_owner;
            if (m_decide) begin
                m_win = -1;
                for (int k = 1; k <= N; k++)
                    if (m_win < 0 && bit_of(HBUSREQ, (m_owner + k) % N)) m_win = (m_owner + k) % N;
                if (m_win < 0) begin
                    m_owner = 0; m_lock = 0; m_beats = 0; m_mode = M_PARK;
                end else begin
                    m_start = (HTRANS == NONSEQ) && !m_err && (m_win == m_owner) && (m_len > 0);
                    m_lock  = bit_of(HLOCK, m_win);
                    m_owner = m_win;
                    m_beats = m_start ? m_len - 1 : 0;
                    m_mode  = m_start ? M_BURST : M_ACTIVE;
                end
            end else if (HTRANS == NONSEQ) begin
                m_beats = (m_len > 0) ? m_len - 1 : 0;
                m_mode  = (m_len > 0) ? M_BURST : M_ACTIVE;
            end else if (m_mode == M_BURST && HTRANS == SEQ) begin
                m_beats = m_beats - 1;
            end
        end
    end

    always @(negedge HCLK) begin
        if (check_en) begin
            chk("model_hgrant", 32'(HGRANT), 32'(1) << m_owner);
            chk("model_hmaster", 32'(HMASTER), m_owner);
            chk("model_hmaster_data", 32'(HMASTER_DATA), m_data);
            chk("model_hmastlock", 32'(HMASTLOCK), m_lock);
            chk("model_beats_left", 32'(dut.beats_left), m_beats);
        end
    end

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_in(input logic [N-1:0] req, input logic [N-1:0] lock, input logic [1:0] tr,
                          input logic [2:0] bu, input logic rdy, input logic [1:0] resp);
        HBUSREQ = req; HLOCK = lock; HTRANS = tr; HBURST = bu; HREADY = rdy; HRESP = resp;
    endtask

    task automatic do_reset();
        set_in('0, '0, IDLE, 3'b000, 1'b1, OKAY);
        HRESET = 1;
        cyc(); cyc();
        HRESET = 0;
    endtask

    int exp_beats;

    initial begin
        HRESET = 1;
        set_in('0, '0, IDLE, 3'b000, 1'b1, OKAY);
        cyc();
        check_en = 1;
        do_reset();

        // Reset values and parking with no requests
        chk("rst_hgrant", 32'(HGRANT), 32'h1);
        chk("rst_hmaster", 32'(HMASTER), 0);
        chk("rst_hmaster_data", 32'(HMASTER_DATA), 0);
        chk("rst_hmastlock", 32'(HMASTLOCK), 0);
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("park_hgrant", 32'(HGRANT), 32'h1);
            chk("park_hmaster", 32'(HMASTER), 0);
        end

        // All masters request SINGLE transfers: rotation 1,2,3,0,1
        do_reset();
        set_in(4'b1111, '0, NONSEQ, 3'b000, 1'b1, OKAY);
        begin
            int seq_m[5] = '{1, 2, 3, 0, 1};
            int seq_d[5] = '{0, 1, 2, 3, 0};
            for (int c = 0; c < 5; c++) begin
                cyc();
                chk("rr_hmaster", 32'(HMASTER), seq_m[c]);
                chk("rr_hmaster_data", 32'(HMASTER_DATA), seq_d[c]);
            end
        end

        // Master 2 INCR8, master 3 requests from beat 2, two wait states at beat 4
        do_reset();
        set_in(4'b0100, '0, IDLE, 3'b000, 1'b1, OKAY);
        cyc();
        chk("incr8_own", 32'(HMASTER), 2);
        set_in(4'b0100, '0, NONSEQ, 3'b101, 1'b1, OKAY);
        cyc();
        chk("incr8_load", 32'(dut.beats_left), 7);
        exp_beats = 7;
        set_in(4'b1100, '0, SEQ, 3'b101, 1'b1, OKAY);
        for (int beat = 2; beat <= 8; beat++) begin
            if (beat == 4) begin
                HREADY = 0;
                repeat (2) begin
                    cyc();
                    chk("incr8_wait_beats", 32'(dut.beats_left), exp_beats);
                    chk("incr8_wait_data", 32'(HMASTER_DATA), 2);
                end
                HREADY = 1;
            end
            cyc();
            exp_beats--;
            chk("incr8_beats", 32'(dut.beats_left), exp_beats);
            chk("incr8_owner", 32'(HMASTER), (beat == 8) ? 3 : 2);
        end

        // Master 1 locked for 6 transfers, then released
        do_reset();
        set_in(4'b1111, 4'b0010, NONSEQ, 3'b000, 1'b1, OKAY);
        for (int c = 0; c < 7; c++) begin
            cyc();
            chk("lock_hmaster", 32'(HMASTER), 1);
            chk("lock_hmastlock", 32'(HMASTLOCK), 1);
        end
        HLOCK = '0;
        cyc();
        chk("unlock_hmaster", 32'(HMASTER), 2);
        chk("unlock_hmastlock", 32'(HMASTLOCK), 0);

        // Master 0 INCR16 hit by ERROR at beat 5
        do_reset();
        set_in(4'b0001, '0, NONSEQ, 3'b111, 1'b1, OKAY);
        cyc();
        chk("err_load", 32'(dut.beats_left), 15);
        set_in(4'b1011, '0, SEQ, 3'b111, 1'b1, OKAY);
        repeat (3) cyc();
        chk("err_pre_beats", 32'(dut.beats_left), 12);
        chk("err_pre_owner", 32'(HMASTER), 0);
        HRESP = ERROR;
        cyc();
        chk("err_beats", 32'(dut.beats_left), 0);
        chk("err_hgrant", 32'(HGRANT), 32'h2);
        HRESP = OKAY;

        // Reset in the middle of a locked INCR4
        do_reset();
        set_in(4'b0100, 4'b0100, IDLE, 3'b000, 1'b1, OKAY);
        cyc();
        chk("midrst_lock", 32'(HMASTLOCK), 1);
        set_in(4'b0100, 4'b0100, NONSEQ, 3'b011, 1'b1, OKAY);
        cyc();
        HTRANS = SEQ;
        cyc();
        chk("midrst_pre_beats", 32'(dut.beats_left), 2);
        HRESET = 1;
        cyc();
        HRESET = 0;
        chk("midrst_hgrant", 32'(HGRANT), 32'h1);
        chk("midrst_hmaster", 32'(HMASTER), 0);
        chk("midrst_hmaster_data", 32'(HMASTER_DATA), 0);
        chk("midrst_hmastlock", 32'(HMASTLOCK), 0);
        chk("midrst_beats", 32'(dut.beats_left), 0);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = $urandom_range(0, 9);
            HRESET  = ($urandom_range(0, 199) == 0);
            HBUSREQ = N'($urandom);
            HLOCK   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            HTRANS  = (r < 1) ? IDLE : (r < 2) ? 2'b01 : (r < 4) ? NONSEQ : SEQ;
            HBURST  = 3'($urandom);
            HREADY  = ($urandom_range(0, 3) != 0);
            HRESP   = ($urandom_range(0, 24) == 0) ? ERROR : OKAY;
            cyc();
        end

        @(posedge HCLK);
        check_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of requesting masters, legal range 2..8.
REQ-002 Parameter MW, default $clog2(NUM_MASTERS): width of the master index.
REQ-003 Port HCLK, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port HRESET, input, 1: synchronous, active-high reset.
REQ-005 Port HBUSREQ, input, NUM_MASTERS: per-master bus request, bit i = master i.
REQ-006 Port HLOCK, input, NUM_MASTERS: per-master locked-transfer request.
REQ-007 Port HTRANS, input, 2: address-phase transfer type of the current owner (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-008 Port HBURST, input, 3: burst type of the current owner (SINGLE=000, INCR=001, WRAP4/INCR4=01x, WRAP8/INCR8=10x, WRAP16/INCR16=11x).
REQ-009 Port HREADY, input, 1: the bus-level ready produced by the slave response mux.
REQ-010 Port HRESP, input, 2: bus-level response; ERROR=01.
REQ-011 Port HGRANT, output, NUM_MASTERS: one-hot grant, registered.
REQ-012 Port HMASTER, output, MW: index of the address-phase owner, registered.
REQ-013 Port HMASTER_DATA, output, MW: index of the data-phase owner, registered.
REQ-014 Port HMASTLOCK, output, 1: the current address phase is locked, registered.

Function
REQ-015 State machine states: PARK (no requester; master 0 owns the bus), ACTIVE (owner issuing SINGLE/INCR or IDLE transfers), BURST (fixed-length burst in progress).
REQ-016 HGRANT, HMASTER and HMASTLOCK shall change only on a clock edge where HREADY=1 and an arbitration point exists.
REQ-017 Arbitration point: state PARK or ACTIVE with HLOCK[owner]=0, or state BURST with beats_left=1 and HTRANS=SEQ, or any state with HRESP=ERROR and HREADY=1.
REQ-018 Winner selection: round-robin over HBUSREQ, starting at (HMASTER+1) mod NUM_MASTERS and wrapping, with the current owner considered last.
REQ-019 If HBUSREQ is all zero at an arbitration point, grant master 0, set HMASTLOCK=0 and enter PARK.
REQ-020 A new grant shall take effect one cycle after the decision edge; HGRANT shall always equal the one-hot encoding of HMASTER.
REQ-021 HMASTLOCK shall be loaded with HLOCK[winner] at each grant edge.
REQ-022 While HLOCK[owner]=1 in PARK or ACTIVE, the owner shall retain the grant regardless of other requests.
REQ-023 beats_left (5-bit) on an accepted NONSEQ (HREADY=1): load 3, 7 or 15 for 4-, 8- or 16-beat bursts and enter BURST; for SINGLE or INCR, load 0 and stay in or enter ACTIVE.
REQ-024 In BURST, each accepted SEQ (HREADY=1) shall decrement beats_left; BUSY and wait states (HREADY=0) shall hold it.
REQ-025 When the last SEQ is accepted (beats_left=1 to 0), return to ACTIVE or PARK according to the arbitration result on that same edge.
REQ-026 HTRANS=IDLE while in BURST (early termination) shall clear beats_left and make that cycle an arbitration point.
REQ-027 HRESP=ERROR with HREADY=1 shall clear beats_left, abandon BURST and re-arbitrate on that edge.
REQ-028 HMASTER_DATA shall load HMASTER on every edge where HREADY=1 and hold otherwise.
REQ-029 A NONSEQ accepted on the same edge as a grant change belongs to the outgoing owner and shall not start a burst count for the new owner.
REQ-030 HREADY=0 shall freeze all state, counters and outputs.

Reset
REQ-031 On HRESET=1 at a clock edge: HGRANT=1 (one-hot, master 0), HMASTER=0, HMASTER_DATA=0, HMASTLOCK=0, beats_left=0, state=PARK.
REQ-032 Reset asserted mid-burst shall abandon the burst with no residual count or lock.
REQ-033 On the first edge after reset deasserts, normal arbitration applies with master 0 treated as the last owner.

Verification
REQ-034 After reset, HBUSREQ=0000 for 5 cycles -> HGRANT=0001, HMASTER=0, state PARK throughout.
REQ-035 HBUSREQ=1111 held, every master issues SINGLE transfers, HREADY=1 -> HMASTER sequence 1,2,3,0,1 on consecutive grants; HMASTER_DATA lags HMASTER by one cycle.
REQ-036 Master 2 owns the bus and issues INCR8; master 3 requests from beat 2; 2 wait states injected at beat 4 -> grant moves to 3 only on the edge accepting the 8th beat, and beats_left holds during the wait states.
REQ-037 Master 1 holds HLOCK=1 and HBUSREQ=1 for 6 transfers while all others request -> HMASTER=1 and HMASTLOCK=1 for all 6; the first non-locked arbitration point grants 2.
REQ-038 Master 0 is in INCR16 at beat 5 when HRESP=ERROR with HREADY=1 -> beats_left=0 and the grant moves to the next requester on that edge.
REQ-039 HRESET=1 asserted mid-INCR4 -> all outputs equal their REQ-031 values on the next edge.
